// File: rtl/axis_gearbox_pkg.sv
// axis_gearbox_pkg: shared sizing helpers and the byte-count function for the
// AXI-Stream byte-lane gearbox.
package axis_gearbox_pkg;

  // Widest tkeep the popcount helper can handle (512-bit bus).
  localparam int KEEP_MAX = 64;

  typedef logic [7:0] byte_t;

  // Byte lanes carried by a bus of the given bit width.
  function automatic int lanes(input int width);
    return width / 8;
  endfunction

  // Holding buffer size in bytes: one full input beat on top of a full output word.
  function automatic int buf_lanes(input int s_width, input int m_width);
    return lanes(s_width) + lanes(m_width);
  endfunction

  // Bits needed to hold a byte count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Number of set bits in a keep vector.
  function automatic int popcount(input logic [KEEP_MAX-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_gearbox_if.sv
// axis_gearbox_if: one AXI-Stream link (data, keep, last, id, dest, user).
//
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are
// both high. Once tvalid is raised the source holds the beat stable until that
// transfer; tready may change freely and the source never waits for tready
// before raising tvalid.
interface axis_gearbox_if
  import axis_gearbox_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);

  logic [DATA_WIDTH-1:0]        tdata;
  logic [lanes(DATA_WIDTH)-1:0] tkeep;
  logic                         tvalid;
  logic                         tready;
  logic                         tlast;
  logic [ID_WIDTH-1:0]          tid;
  logic [DEST_WIDTH-1:0]        tdest;
  logic [USER_WIDTH-1:0]        tuser;

  // Source side of the link.
  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  // Sink side of the link.
  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_gearbox_popcnt.sv
// axis_gearbox_popcnt: turns an input tkeep vector into the number of valid
// bytes in the beat. Keep is assumed contiguous from bit 0, so the count also
// tells which lanes carry data.
module axis_gearbox_popcnt
  import axis_gearbox_pkg::*;
#(
  parameter int LANES = 3,
  parameter int CNT_W = 3
) (
  input  logic [LANES-1:0] i_keep,
  output logic [CNT_W-1:0] o_count
);

  logic [KEEP_MAX-1:0] w_keep_ext;

  assign w_keep_ext = KEEP_MAX'(i_keep);
  assign o_count    = CNT_W'(popcount(w_keep_ext));

endmodule

// File: rtl/axis_gearbox.sv
// axis_gearbox: AXI-Stream byte-lane width converter for any S:M lane ratio.
//
// Bytes are collected in a small shift buffer (oldest byte in lane 0). A full
// output word is offered whenever M_LANES bytes are held; the tail of a frame is
// offered once its tlast beat has been accepted. New frames are held off until
// the previous frame's final beat has left, so a frame always starts at lane 0.
//
// Build option: define AXIS_GEARBOX_LEVEL_EN to add the buf_level output, which
// reports the registered byte count of the buffer.
module axis_gearbox
  import axis_gearbox_pkg::*;
#(
  parameter int S_DATA_WIDTH = 24,
  parameter int M_DATA_WIDTH = 32,
  parameter int ID_ENABLE    = 0,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_ENABLE  = 0,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AXIS_GEARBOX_LEVEL_EN
  output logic [cnt_width(buf_lanes(S_DATA_WIDTH, M_DATA_WIDTH))-1:0] buf_level,
`endif
  axis_gearbox_if.slave  s_axis,
  axis_gearbox_if.master m_axis
);

  localparam int S_LANES   = lanes(S_DATA_WIDTH);
  localparam int M_LANES   = lanes(M_DATA_WIDTH);
  localparam int BUF_LANES = buf_lanes(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int BUF_W     = BUF_LANES * 8;
  localparam int CNT_W     = cnt_width(BUF_LANES);
  localparam logic [CNT_W-1:0] M_CNT = CNT_W'(M_LANES);

  // Byte lanes only: a partial-byte bus cannot be regrouped.
  if (((S_DATA_WIDTH % 8) != 0) || ((M_DATA_WIDTH % 8) != 0)) begin : g_width_check
    $fatal(1, "axis_gearbox: S_DATA_WIDTH and M_DATA_WIDTH must be multiples of 8");
  end

  // Registered state
  logic [BUF_W-1:0]      r_buf;          // byte buffer, lane 0 is the oldest byte
  logic [CNT_W-1:0]      r_count;        // valid bytes in r_buf
  logic                  r_last_pending; // tlast accepted, final beat not yet sent
  logic                  r_ready_en;     // keeps s_axis.tready low until out of reset
  logic                  r_in_frame;     // a frame has started but its tlast not seen
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user_acc;     // sticky OR of tuser over the frame

  // Combinational datapath
  logic [CNT_W-1:0]      w_in_bytes;
  logic                  w_s_ready;
  logic                  w_accept;
  logic                  w_full_word;
  logic                  w_m_valid;
  logic                  w_final;
  logic                  w_emit;
  logic [CNT_W-1:0]      w_rm;
  logic [CNT_W-1:0]      w_count_mid;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [BUF_W-1:0]      w_shifted;
  logic [BUF_W-1:0]      w_in_raw;
  logic [BUF_W-1:0]      w_in_ext;
  logic [BUF_W-1:0]      w_buf_nxt;
  logic [M_LANES-1:0]    w_m_keep;

  axis_gearbox_popcnt #(
    .LANES (S_LANES),
    .CNT_W (CNT_W)
  ) u_popcnt (
    .i_keep  (s_axis.tkeep),
    .o_count (w_in_bytes)
  );

  // Ready depends only on registered state, so m_axis.tready never reaches it.
  assign w_s_ready   = r_ready_en && !r_last_pending && (r_count <= M_CNT);
  assign w_accept    = s_axis.tvalid && w_s_ready;

  // A full word is always sendable; a short tail only once the frame has ended.
  assign w_full_word = (r_count >= M_CNT);
  assign w_m_valid   = w_full_word || r_last_pending;
  assign w_final     = r_last_pending && (r_count <= M_CNT);
  assign w_emit      = w_m_valid && m_axis.tready;

  // Bytes leaving this cycle, what remains, and the count after the append.
  assign w_rm        = w_emit ? (w_full_word ? M_CNT : r_count) : '0;
  assign w_count_mid = r_count - w_rm;
  assign w_count_nxt = w_count_mid + (w_accept ? w_in_bytes : '0);

  assign w_in_raw    = BUF_W'(s_axis.tdata);

  // Next buffer: shift out emitted bytes, append accepted bytes behind the
  // remainder, and clear every lane above the new count.
  always_comb begin
    w_shifted = r_buf >> {w_rm, 3'b000};
    w_in_ext  = w_in_raw << {w_count_mid, 3'b000};
    w_buf_nxt = '0;
    for (int j = 0; j < BUF_LANES; j++) begin
      if (CNT_W'(j) < w_count_mid) begin
        w_buf_nxt[j*8 +: 8] = w_shifted[j*8 +: 8];
      end else if (w_accept && (CNT_W'(j) < w_count_nxt)) begin
        w_buf_nxt[j*8 +: 8] = w_in_ext[j*8 +: 8];
      end
    end
  end

  // Buffer, count and frame bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf          <= '0;
      r_count        <= '0;
      r_last_pending <= 1'b0;
      r_ready_en     <= 1'b0;
      r_in_frame     <= 1'b0;
      r_id           <= '0;
      r_dest         <= '0;
      r_user_acc     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_buf      <= w_buf_nxt;
      r_count    <= w_count_nxt;
      // Final beat of the frame leaves: the frame is closed.
      if (w_emit && w_final) begin
        r_last_pending <= 1'b0;
        r_user_acc     <= '0;
      end
      // Accept and final emit are exclusive because ready needs !r_last_pending.
      if (w_accept) begin
        if (!r_in_frame) begin
          r_id   <= s_axis.tid;
          r_dest <= s_axis.tdest;
        end
        r_in_frame <= !s_axis.tlast;
        r_user_acc <= r_user_acc | s_axis.tuser;
        if (s_axis.tlast) begin
          r_last_pending <= 1'b1;
        end
      end
    end
  end

  // Output keep: low lanes up to min(count, M_LANES).
  always_comb begin
    w_m_keep = '0;
    for (int j = 0; j < M_LANES; j++) begin
      w_m_keep[j] = (CNT_W'(j) < r_count);
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = w_m_valid;
  assign m_axis.tdata  = r_buf[M_LANES*8-1:0];
  assign m_axis.tkeep  = w_m_keep;
  assign m_axis.tlast  = w_final;
  assign m_axis.tid    = (ID_ENABLE != 0)   ? r_id   : '0;
  assign m_axis.tdest  = (DEST_ENABLE != 0) ? r_dest : '0;
  assign m_axis.tuser  = ((USER_ENABLE != 0) && w_final) ? r_user_acc : '0;

`ifdef AXIS_GEARBOX_LEVEL_EN
  assign buf_level = r_count;
`endif

endmodule

// File: tb/tb_axis_gearbox.sv
// tb_axis_gearbox: self-checking bench for axis_gearbox (24-bit in, 32-bit out).
// Expected output beats come from a frame-level model: all kept bytes of a
// frame are gathered and cut into 4-byte words, the last word carries tlast
// and the OR of tuser, every word carries the first beat's tid/tdest.
module tb_axis_gearbox;

  localparam int SW = 24;
  localparam int MW = 32;
  localparam int IW = 8;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int SL = SW / 8;
  localparam int ML = MW / 8;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [ML-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
    logic [DW-1:0] dest;
    logic [UW-1:0] user;
  } beat_t;

  localparam int EXP_W = $bits(beat_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_gearbox_if #(.DATA_WIDTH(SW), .ID_WIDTH(IW), .DEST_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
  axis_gearbox_if #(.DATA_WIDTH(MW), .ID_WIDTH(IW), .DEST_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

`ifdef AXIS_GEARBOX_LEVEL_EN
  logic [$clog2(SL+ML+1)-1:0] buf_level;
`endif

  axis_gearbox #(
    .S_DATA_WIDTH (SW),
    .M_DATA_WIDTH (MW),
    .ID_ENABLE    (1),
    .ID_WIDTH     (IW),
    .DEST_ENABLE  (1),
    .DEST_WIDTH   (DW),
    .USER_ENABLE  (1),
    .USER_WIDTH   (UW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef AXIS_GEARBOX_LEVEL_EN
    .buf_level (buf_level),
`endif
    .s_axis (s_if),
    .m_axis (m_if)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_mode  = 0; // 0: always ready, 1: random ready, 2: held low

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- frame description + model ----------------
  logic [SW-1:0] fr_data[8];
  logic [SL-1:0] fr_keep[8];
  logic [UW-1:0] fr_user[8];
  int            fr_n;
  logic [IW-1:0] fr_id;
  logic [DW-1:0] fr_dest;

  task automatic push_exp(input logic [MW-1:0] d, input logic [ML-1:0] k, input logic l,
                          input logic [IW-1:0] id, input logic [DW-1:0] de, input logic [UW-1:0] u);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.id = id; b.dest = de; b.user = u;
    exp_q.push_back(b);
  endtask

  task automatic model_push_frame();
    logic [7:0]    bytes[$];
    logic [UW-1:0] uor;
    logic [MW-1:0] d;
    logic [ML-1:0] k;
    int            n;
    int            cnt;
    uor = '0;
    for (int i = 0; i < fr_n; i++) begin
      uor |= fr_user[i];
      for (int b = 0; b < SL; b++) begin
        if (fr_keep[i][b]) bytes.push_back(fr_data[i][b*8 +: 8]);
      end
    end
    n = bytes.size();
    if (n == 0) begin
      push_exp('0, '0, 1'b1, fr_id, fr_dest, uor);
    end else begin
      for (int off = 0; off < n; off += ML) begin
        cnt = ((n - off) < ML) ? (n - off) : ML;
        d = '0;
        k = '0;
        for (int b = 0; b < cnt; b++) begin
          d[b*8 +: 8] = bytes[off + b];
          k[b] = 1'b1;
        end
        if (off + ML >= n) push_exp(d, k, 1'b1, fr_id, fr_dest, uor);
        else               push_exp(d, k, 1'b0, fr_id, fr_dest, '0);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [SW-1:0] d, input logic [SL-1:0] k, input logic l,
                           input logic [IW-1:0] id, input logic [DW-1:0] de, input logic [UW-1:0] u);
    int waited;
    waited = 0;
    @(negedge clk);
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l;
    s_if.tid = id; s_if.tdest = de; s_if.tuser = u;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check_eq("s_tready_wait", s_if.tready, 1);
    if (s_if.tready) @(posedge clk);
    #1 s_if.tvalid = 1'b0;
  endtask

  task automatic drive_frame(input int gap_max);
    for (int i = 0; i < fr_n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(fr_data[i], fr_keep[i], (i == fr_n - 1),
                (i == 0) ? fr_id : IW'($urandom), (i == 0) ? fr_dest : DW'($urandom),
                fr_user[i]);
    end
  endtask

  task automatic gen_random_frame();
    fr_id   = IW'($urandom);
    fr_dest = DW'($urandom);
    if ($urandom_range(0, 9) == 0) begin
      fr_n = 1;
      fr_data[0] = SW'($urandom);
      fr_keep[0] = '0;
      fr_user[0] = UW'($urandom_range(0, 1));
    end else begin
      fr_n = $urandom_range(1, 5);
      for (int i = 0; i < fr_n; i++) begin
        fr_data[i] = SW'($urandom);
        fr_keep[i] = '1;
        fr_user[i] = ($urandom_range(0, 3) == 0) ? UW'(1) : UW'(0);
      end
      case ($urandom_range(0, 2))
        0:       fr_keep[fr_n-1] = 3'b001;
        1:       fr_keep[fr_n-1] = 3'b011;
        default: fr_keep[fr_n-1] = 3'b111;
      endcase
    end
  endtask

  task automatic set_frame_27(input logic [IW-1:0] id);
    fr_n = 3; fr_id = id; fr_dest = 8'h00;
    fr_data[0] = 24'h030201; fr_keep[0] = 3'b111; fr_user[0] = 1'b0;
    fr_data[1] = 24'h060504; fr_keep[1] = 3'b111; fr_user[1] = 1'b0;
    fr_data[2] = 24'hABCD07; fr_keep[2] = 3'b001; fr_user[2] = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check_eq("idle_tvalid", m_if.tvalid, 0);
  endtask

  // ---------------- output monitor / scoreboard ----------------
  initial begin
    beat_t e;
    m_if.tready = 1'b0;
    forever begin
      @(negedge clk);
      case (m_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ($urandom_range(0, 3) != 0);
        default: m_if.tready = 1'b0;
      endcase
      if (rst_n === 1'b1 && m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", m_if.tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("m_tdata", m_if.tdata, e.data);
          check_eq("m_tkeep", m_if.tkeep, e.keep);
          check_eq("m_tlast", m_if.tlast, e.last);
          check_eq("m_tid",   m_if.tid,   e.id);
          check_eq("m_tdest", m_if.tdest, e.dest);
          check_eq("m_tuser", m_if.tuser, e.user);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;
    rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_m_tvalid", m_if.tvalid, 0);
    check_eq("rst_s_tready", s_if.tready, 0);
    check_eq("rst_m_tlast",  m_if.tlast, 0);
    check_eq("rst_m_tkeep",  m_if.tkeep, 0);
    check_eq("rst_m_tuser",  m_if.tuser, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_s_tready", s_if.tready, 1);

    // Basic 3:4 regrouping with fixed expected words
    m_mode = 0;
    set_frame_27(8'h00);
    push_exp(32'h04030201, 4'hF, 1'b0, 8'h00, 8'h00, 1'b0);
    push_exp(32'h00070605, 4'h7, 1'b1, 8'h00, 8'h00, 1'b0);
    drive_frame(0);
    drain();

    // Same frame with the sink stalled
    m_mode = 2;
    set_frame_27(8'h00);
    push_exp(32'h04030201, 4'hF, 1'b0, 8'h00, 8'h00, 1'b0);
    push_exp(32'h00070605, 4'h7, 1'b1, 8'h00, 8'h00, 1'b0);
    send_beat(fr_data[0], fr_keep[0], 1'b0, fr_id, fr_dest, fr_user[0]);
    @(negedge clk);
    check_eq("count3_s_tready", s_if.tready, 1);
    send_beat(fr_data[1], fr_keep[1], 1'b0, fr_id, fr_dest, fr_user[1]);
    @(negedge clk);
    check_eq("count6_s_tready", s_if.tready, 0);
    check_eq("count6_m_tvalid", m_if.tvalid, 1);
    repeat (5) @(negedge clk);
    check_eq("stall_tdata", m_if.tdata, 32'h04030201);
    @(posedge clk);
    m_mode = 0;
    send_beat(fr_data[2], fr_keep[2], 1'b1, fr_id, fr_dest, fr_user[2]);
    drain();

    // tuser on beat 2 only, tid 3 latched from the first beat
    m_mode = 1;
    set_frame_27(8'h03);
    fr_dest = 8'h5A;
    fr_user[1] = 1'b1;
    model_push_frame();
    drive_frame(1);
    drain();

    // Zero-byte tlast beat into an empty buffer
    fr_n = 1; fr_id = 8'h11; fr_dest = 8'h22;
    fr_data[0] = 24'hFFFFFF; fr_keep[0] = 3'b000; fr_user[0] = 1'b0;
    push_exp(32'h0, 4'h0, 1'b1, 8'h11, 8'h22, 1'b0);
    drive_frame(0);
    drain();

`ifdef AXIS_GEARBOX_LEVEL_EN
    // Buffer level tracking
    @(posedge clk);
    m_mode = 2;
    set_frame_27(8'h07);
    model_push_frame();
    send_beat(fr_data[0], fr_keep[0], 1'b0, fr_id, fr_dest, fr_user[0]);
    @(negedge clk);
    check_eq("level_after_b1", buf_level, 3);
    send_beat(fr_data[1], fr_keep[1], 1'b0, fr_id, fr_dest, fr_user[1]);
    @(negedge clk);
    check_eq("level_after_b2", buf_level, 6);
    @(posedge clk);
    m_mode = 0;
    @(posedge clk);
    m_mode = 2;
    @(negedge clk);
    check_eq("level_after_emit", buf_level, 2);
    @(posedge clk);
    m_mode = 0;
    send_beat(fr_data[2], fr_keep[2], 1'b1, fr_id, fr_dest, fr_user[2]);
    drain();
`endif

    // Mid-frame reset drops the partial frame
    @(posedge clk);
    m_mode = 2;
    send_beat(24'h332211, 3'b111, 1'b0, 8'h44, 8'h55, 1'b1);
    send_beat(24'h665544, 3'b111, 1'b0, 8'h66, 8'h77, 1'b0);
    @(negedge clk);
    check_eq("pre_rst_m_tvalid", m_if.tvalid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_m_tvalid", m_if.tvalid, 0);
    check_eq("mid_rst_s_tready", s_if.tready, 0);
    check_eq("mid_rst_m_tkeep",  m_if.tkeep, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rise_s_tready", s_if.tready, 1);
    check_eq("mid_rst_rise_m_tvalid", m_if.tvalid, 0);
    @(posedge clk);
    m_mode = 0;
    fr_n = 2; fr_id = 8'h09; fr_dest = 8'h0A;
    fr_data[0] = 24'hA3A2A1; fr_keep[0] = 3'b111; fr_user[0] = 1'b0;
    fr_data[1] = 24'hA6A5A4; fr_keep[1] = 3'b011; fr_user[1] = 1'b0;
    model_push_frame();
    drive_frame(0);
    drain();

    // Randomized frames against the model
    m_mode = 1;
    for (int f = 0; f < 40; f++) begin
      gen_random_frame();
      model_push_frame();
      drive_frame(2);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_gearbox.md
AXIS_GEARBOX -- requirements
Module: axis_gearbox

Interface
REQ-001 SHALL have parameter S_DATA_WIDTH, default 24: input tdata width in bits.
REQ-002 SHALL have parameter M_DATA_WIDTH, default 32: output tdata width in bits.
REQ-003 SHALL have parameters ID_ENABLE=0, ID_WIDTH=8, DEST_ENABLE=0, DEST_WIDTH=8, USER_ENABLE=1, USER_WIDTH=1, each a propagate flag or a width.
REQ-004 SHALL have ports clk in 1 (sole clock) and rst_n in 1; one clock, reset asynchronous and active-low.
REQ-005 SHALL have ports s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser: inputs except tready (output); widths S_DATA_WIDTH, S_DATA_WIDTH/8, 1, 1, 1, ID_WIDTH, DEST_WIDTH, USER_WIDTH.
REQ-006 SHALL have ports m_axis_* mirroring REQ-005 in opposite direction; widths M_DATA_WIDTH, M_DATA_WIDTH/8, 1, 1, 1, ID_WIDTH, DEST_WIDTH, USER_WIDTH.

Function
REQ-007 SHALL accept any byte-lane ratio S_LANES:M_LANES (S_LANES = S_DATA_WIDTH/8, M_LANES = M_DATA_WIDTH/8), integer or not; a width not divisible by 8 is a fatal elaboration error.
REQ-008 SHALL hold bytes in a register buffer of BUF_LANES = S_LANES+M_LANES bytes plus a byte count, with the oldest byte at lane 0.
REQ-009 SHALL drive s_axis_tready = !last_pending && count <= M_LANES, registered state only, with no path from m_axis_tready.
REQ-010 SHALL require input tkeep contiguous from bit 0; non-last beats all ones; byte count of a beat = popcount(tkeep).
REQ-011 SHALL on an accepted beat append its bytes at position count (count after any same-cycle emit).
REQ-012 SHALL drive m_axis_tvalid = count >= M_LANES || (last_pending && no full word left), with m_axis_tdata = buffer lanes 0..M_LANES-1 direct from registers.
REQ-013 SHALL on m_axis_tvalid && m_axis_tready remove min(count, M_LANES) bytes and shift the remainder down; an emit and an accept in the same cycle are both applied.
REQ-014 SHALL drive m_axis_tkeep low-contiguous with popcount = min(count, M_LANES); m_axis_tlast=1 only on the final beat of a frame.
REQ-015 SHALL set last_pending when a tlast beat is accepted, and clear it when the beat carrying tlast is emitted.
REQ-016 SHALL emit exactly one beat with tkeep=0, tlast=1 for a zero-byte tlast beat arriving with an empty buffer.
REQ-017 SHALL latch tid and tdest from the first accepted beat of a frame and hold them for every output beat of that frame.
REQ-018 SHALL OR tuser across all input beats of a frame, present it only on the tlast output beat, and drive 0 on other beats.
REQ-019 SHALL tie disabled tid/tdest/tuser outputs to 0.
REQ-020 SHALL have input-to-output latency of 1 cycle minimum; sustained full throughput is not required.

Reset
REQ-021 SHALL during rst_n=0 force count=0, last_pending=0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tuser=0 and the sticky tuser OR to 0.
REQ-022 SHALL drop any partial frame on mid-frame reset, and raise s_axis_tready in the first cycle after deassertion.

Configuration
REQ-023 SHALL with AXIS_GEARBOX_LEVEL_EN defined add output port buf_level, width $clog2(BUF_LANES+1), equal to count registered.
REQ-024 SHALL without AXIS_GEARBOX_LEVEL_EN have no such port, with function otherwise identical.

Structure
REQ-025 SHALL place the lane-count/buffer-size helper functions and the popcount function in package axis_gearbox_pkg.
REQ-026 SHALL use one sub-module, axis_gearbox_popcnt, to convert tkeep to a byte count.

Verification (S=24, M=32 bits)
REQ-027 SHALL test: beats {01,02,03},{04,05,06},{07 keep=001 last} -> out {01..04 keep=F}, {05,06,07 keep=7 last}.
REQ-028 SHALL test: same frame with m_axis_tready low 5 cycles -> no loss or duplication; tready drops once count>4.
REQ-029 SHALL test: tuser=1 on beat 2 only -> tuser=1 on tlast output beat only; tid=3 latched on all beats.
REQ-030 SHALL test: tkeep=000 with tlast, buffer empty -> single beat keep=0 last=1.
REQ-031 SHALL test: rst_n pulsed after 2 input beats -> tvalid=0 at once; next frame is clean with no stale bytes.
REQ-032 SHALL test with AXIS_GEARBOX_LEVEL_EN: after first input beat buf_level=3; after 2nd=6; after emit=2.
